// File: rtl/wisc_pkg.sv
// -----------------------------------------------------------------------------
// wisc_pkg
// Constants and types shared by the IF/ID stage of the 16-bit WISC core:
//   OPC_HLT            opcode of the halt instruction
//   NOP_INSTR_DEFAULT  encoding used for reset, flush and bubble contents
//   halt_state_t       halt FSM encoding (RUN=0, DRAIN=1, HALTED=2)
//   field indices      opcode and immediate slice positions within an instr
//   is_hlt()           true when a valid instruction carries the HLT opcode
// -----------------------------------------------------------------------------
package wisc_pkg;

    localparam logic [3:0]  OPC_HLT           = 4'hF;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

    localparam int INSTR_W   = 16;
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int IMM4_MSB  = 3;
    localparam int IMM9_MSB  = 8;
    localparam int IMM12_MSB = 11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_t;

    function automatic logic is_hlt(input logic valid, input logic [INSTR_W-1:0] instr);
        return valid & (instr[OPC_MSB:OPC_LSB] == OPC_HLT);
    endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg_if
// Bundles the fetch-side inputs, hazard controls and decode-side outputs of the
// IF/ID pipeline register.
//   fetch side : if_instr_i, if_pc_plus2_i, if_valid_i
//   hazard     : stall_i, flush_i
//   decode side: id_instr_o, id_pc_plus2_o, id_valid_o,
//                id_imm4_o / id_imm9_o / id_imm12_o (only with IFID_IMM_FIELDS_EN)
//   halt       : fetch_halt_o, halted_o
// Modports:
//   slave  - the pipeline register itself (drives the *_o signals)
//   master - the surrounding pipeline (drives the *_i signals)
// -----------------------------------------------------------------------------
interface if_id_pipe_reg_if;

    logic [15:0] if_instr_i;
    logic [15:0] if_pc_plus2_i;
    logic        if_valid_i;
    logic        stall_i;
    logic        flush_i;

    logic [15:0] id_instr_o;
    logic [15:0] id_pc_plus2_o;
    logic        id_valid_o;
`ifdef IFID_IMM_FIELDS_EN
    logic [3:0]  id_imm4_o;
    logic [8:0]  id_imm9_o;
    logic [11:0] id_imm12_o;
`endif
    logic        fetch_halt_o;
    logic        halted_o;

    modport slave (
        input  if_instr_i, if_pc_plus2_i, if_valid_i, stall_i, flush_i,
        output id_instr_o, id_pc_plus2_o, id_valid_o,
`ifdef IFID_IMM_FIELDS_EN
        output id_imm4_o, id_imm9_o, id_imm12_o,
`endif
        output fetch_halt_o, halted_o
    );

    modport master (
        output if_instr_i, if_pc_plus2_i, if_valid_i, stall_i, flush_i,
        input  id_instr_o, id_pc_plus2_o, id_valid_o,
`ifdef IFID_IMM_FIELDS_EN
        input  id_imm4_o, id_imm9_o, id_imm12_o,
`endif
        input  fetch_halt_o, halted_o
    );

endinterface

// File: rtl/wisc_halt_fsm.sv
// -----------------------------------------------------------------------------
// wisc_halt_fsm
// Freezes fetch once a valid HLT sits in ID, then waits for it to drain through
// EX->MEM->WB before declaring the core halted.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   RUN    | normal operation; fetch stops only while an HLT is sitting in ID
//   DRAIN  | HLT has left ID; counting non-stalled cycles until it retires
//   HALTED | core halted; sticky until reset, flush/stall ignored
//
// Ports:
//   clk, rst_n     clock / async active-low reset
//   hlt_in_id      valid HLT currently held in the IF/ID register
//   stall_i        hazard stall (pauses the drain count)
//   flush_i        taken branch; an older branch squashes the HLT during DRAIN
//   fetch_halt_o   fetch must stop advancing PC
//   halted_o       core halted
// Parameter DRAIN_CYCLES (>=1): cycles from HLT leaving ID until halted_o.
// -----------------------------------------------------------------------------
module wisc_halt_fsm
    import wisc_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hlt_in_id,
    input  logic stall_i,
    input  logic flush_i,
    output logic fetch_halt_o,
    output logic halted_o
);

    localparam int               CNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    halt_state_t      r_state;
    halt_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_RUN: begin
                // The HLT only leaves ID on a cycle that actually advances the pipe.
                if (hlt_in_id && !stall_i && !flush_i) begin
                    w_state_nxt = ST_DRAIN;
                    w_count_nxt = '0;
                end
            end
            ST_DRAIN: begin
                if (flush_i) begin
                    w_state_nxt = ST_RUN;
                    w_count_nxt = '0;
                end else if (!stall_i) begin
                    if (r_count == CNT_LAST) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_count_nxt = '0;
            end
        endcase
    end

    assign fetch_halt_o = hlt_in_id | (r_state != ST_RUN);
    assign halted_o     = (r_state == ST_HALTED);

endmodule

// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
// IF/ID pipeline register of the 16-bit WISC core. Captures the fetched
// instruction and PC+2 and presents them to decode one cycle later. Handles
// flush (highest priority), stall, and HLT: once a valid HLT reaches ID the
// halt FSM freezes fetch and this register loads only bubbles.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     if_id_pipe_reg_if.slave: fetch inputs, stall/flush, ID outputs,
//           fetch_halt_o, halted_o
// Parameters:
//   DRAIN_CYCLES  cycles after HLT leaves ID until halted_o (>=1)
//   NOP_INSTR     encoding loaded on reset, flush or bubble
// Configuration macro:
//   IFID_IMM_FIELDS_EN  when defined, drives id_imm4_o/id_imm9_o/id_imm12_o as
//                       slices of the registered instruction.
// All outputs come from registers only; no if_* input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module if_id_pipe_reg
    import wisc_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    if_id_pipe_reg_if.slave   bus
);

    logic [15:0] r_instr;
    logic [15:0] r_pc_plus2;
    logic        r_valid;

    logic        w_hlt_in_id;
    logic        w_fetch_halt;
    logic        w_halted;

    assign w_hlt_in_id = is_hlt(r_valid, r_instr);

    wisc_halt_fsm #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_halt_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .hlt_in_id    (w_hlt_in_id),
        .stall_i      (bus.stall_i),
        .flush_i      (bus.flush_i),
        .fetch_halt_o (w_fetch_halt),
        .halted_o     (w_halted)
    );

    // Once halted, flush and stall no longer matter: only bubbles are loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else if (w_halted || bus.flush_i) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else if (bus.stall_i) begin
            r_instr    <= r_instr;
            r_pc_plus2 <= r_pc_plus2;
            r_valid    <= r_valid;
        end else if (w_fetch_halt) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_instr    <= bus.if_instr_i;
            r_pc_plus2 <= bus.if_pc_plus2_i;
            r_valid    <= bus.if_valid_i;
        end
    end

    assign bus.id_instr_o    = r_instr;
    assign bus.id_pc_plus2_o = r_pc_plus2;
    assign bus.id_valid_o    = r_valid;
    assign bus.fetch_halt_o  = w_fetch_halt;
    assign bus.halted_o      = w_halted;

`ifdef IFID_IMM_FIELDS_EN
    assign bus.id_imm4_o  = r_instr[IMM4_MSB:0];
    assign bus.id_imm9_o  = r_instr[IMM9_MSB:0];
    assign bus.id_imm12_o = r_instr[IMM12_MSB:0];
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] pc;
        logic        v;
        logic        st;
        logic        fl;
    } stim_t;

    // chk_pc=0 marks bubbles whose PC field is don't-care
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        chk_pc;
        logic        valid;
        logic        fh;
        logic        hd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    if_id_pipe_reg_if bus();

    if_id_pipe_reg #(
        .DRAIN_CYCLES (3),
        .NOP_INSTR    (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input stim_t s);
        @(negedge clk);
        bus.if_instr_i    = s.ins;
        bus.if_pc_plus2_i = s.pc;
        bus.if_valid_i    = s.v;
        bus.stall_i       = s.st;
        bus.flush_i       = s.fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.if_instr_i = '0; bus.if_pc_plus2_i = '0; bus.if_valid_i = 1'b0;
        bus.stall_i = 1'b0;  bus.flush_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        bus.if_instr_i = 16'hF000; bus.if_pc_plus2_i = 16'h1111; bus.if_valid_i = 1'b1;
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.id_instr_o !== 16'h0000 || bus.id_pc_plus2_o !== 16'h0000 || bus.id_valid_o !== 1'b0 ||
            bus.fetch_halt_o !== 1'b0 || bus.halted_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: got instr=%h pc=%h v=%b fh=%b hd=%b want instr=0000 pc=0000 v=0 fh=0 hd=0",
                     bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o, bus.halted_o);
        end
        do_reset();
    endtask

    task automatic test_load();
        stim_t s[3];
        exp_t  e[3];
        exp_t  x;
        s = '{'{16'h1234, 16'h0002, 1'b1, 1'b0, 1'b0},
              '{16'h5678, 16'h0004, 1'b0, 1'b0, 1'b0},
              '{16'hABCD, 16'h0006, 1'b1, 1'b0, 1'b0}};
        e = '{'{16'h1234, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'h5678, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0},
              '{16'hABCD, 16'h0006, 1'b1, 1'b1, 1'b0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(e[i]);
            cyc(s[i]);
            x = sb.pop_front();
            checks++;
            if (bus.id_instr_o !== x.instr || bus.id_valid_o !== x.valid || (x.chk_pc && bus.id_pc_plus2_o !== x.pc) ||
                bus.fetch_halt_o !== x.fh || bus.halted_o !== x.hd) begin
                errors++;
                $display("FAIL load[%0d]: got instr=%h pc=%h v=%b fh=%b hd=%b want instr=%h pc=%h v=%b fh=%b hd=%b", i,
                         bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o, bus.halted_o,
                         x.instr, x.pc, x.valid, x.fh, x.hd);
            end
        end
        // Changing fetch inputs mid-cycle must not reach any output.
        bus.if_instr_i = 16'hF00F; bus.if_pc_plus2_i = 16'h7FFE; bus.if_valid_i = 1'b1;
        #1;
        checks++;
        if (bus.id_instr_o !== 16'hABCD || bus.id_pc_plus2_o !== 16'h0006 || bus.id_valid_o !== 1'b1 ||
            bus.fetch_halt_o !== 1'b0) begin
            errors++;
            $display("FAIL no_comb_path: got instr=%h pc=%h v=%b fh=%b want instr=abcd pc=0006 v=1 fh=0",
                     bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o);
        end
    endtask

    task automatic test_stall();
        stim_t s[5];
        exp_t  e[5];
        exp_t  x;
        s = '{'{16'hA5A5, 16'h0010, 1'b1, 1'b0, 1'b0},
              '{16'hBEEF, 16'h0012, 1'b1, 1'b1, 1'b0},
              '{16'hBEEF, 16'h0012, 1'b1, 1'b1, 1'b0},
              '{16'hBEEF, 16'h0012, 1'b1, 1'b1, 1'b0},
              '{16'hBEEF, 16'h0012, 1'b1, 1'b0, 1'b0}};
        e = '{'{16'hA5A5, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'hA5A5, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'hA5A5, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'hA5A5, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'hBEEF, 16'h0012, 1'b1, 1'b1, 1'b0, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(e[i]);
            cyc(s[i]);
            x = sb.pop_front();
            checks++;
            if (bus.id_instr_o !== x.instr || bus.id_valid_o !== x.valid || (x.chk_pc && bus.id_pc_plus2_o !== x.pc) ||
                bus.fetch_halt_o !== x.fh || bus.halted_o !== x.hd) begin
                errors++;
                $display("FAIL stall[%0d]: got instr=%h pc=%h v=%b fh=%b hd=%b want instr=%h pc=%h v=%b fh=%b hd=%b", i,
                         bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o, bus.halted_o,
                         x.instr, x.pc, x.valid, x.fh, x.hd);
            end
        end
    endtask

    task automatic test_flush();
        stim_t s[3];
        exp_t  e[3];
        exp_t  x;
        s = '{'{16'h7777, 16'h0020, 1'b1, 1'b0, 1'b0},
              '{16'h8888, 16'h0022, 1'b1, 1'b1, 1'b1},
              '{16'h9999, 16'h0024, 1'b1, 1'b0, 1'b0}};
        e = '{'{16'h7777, 16'h0020, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0},
              '{16'h9999, 16'h0024, 1'b1, 1'b1, 1'b0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(e[i]);
            cyc(s[i]);
            x = sb.pop_front();
            checks++;
            if (bus.id_instr_o !== x.instr || bus.id_valid_o !== x.valid || (x.chk_pc && bus.id_pc_plus2_o !== x.pc) ||
                bus.fetch_halt_o !== x.fh || bus.halted_o !== x.hd) begin
                errors++;
                $display("FAIL flush[%0d]: got instr=%h pc=%h v=%b fh=%b hd=%b want instr=%h pc=%h v=%b fh=%b hd=%b", i,
                         bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o, bus.halted_o,
                         x.instr, x.pc, x.valid, x.fh, x.hd);
            end
        end
    endtask

    task automatic test_fake_hlt();
        stim_t s[4];
        exp_t  e[4];
        exp_t  x;
        s = '{'{16'hF123, 16'h0030, 1'b0, 1'b0, 1'b0},
              '{16'h3333, 16'h0032, 1'b1, 1'b0, 1'b0},
              '{16'hFFFF, 16'h0034, 1'b0, 1'b0, 1'b0},
              '{16'h1000, 16'h0036, 1'b1, 1'b0, 1'b0}};
        e = '{'{16'hF123, 16'h0030, 1'b1, 1'b0, 1'b0, 1'b0},
              '{16'h3333, 16'h0032, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'hFFFF, 16'h0034, 1'b1, 1'b0, 1'b0, 1'b0},
              '{16'h1000, 16'h0036, 1'b1, 1'b1, 1'b0, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(e[i]);
            cyc(s[i]);
            x = sb.pop_front();
            checks++;
            if (bus.id_instr_o !== x.instr || bus.id_valid_o !== x.valid || (x.chk_pc && bus.id_pc_plus2_o !== x.pc) ||
                bus.fetch_halt_o !== x.fh || bus.halted_o !== x.hd) begin
                errors++;
                $display("FAIL fake_hlt[%0d]: got instr=%h pc=%h v=%b fh=%b hd=%b want instr=%h pc=%h v=%b fh=%b hd=%b", i,
                         bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o, bus.halted_o,
                         x.instr, x.pc, x.valid, x.fh, x.hd);
            end
        end
    endtask

    // HLT leaves ID at row 1; halted_o must rise exactly 3 edges later (row 4).
    task automatic test_halt();
        stim_t s[7];
        exp_t  e[7];
        exp_t  x;
        do_reset();
        s = '{'{16'hF000, 16'h0040, 1'b1, 1'b0, 1'b0},
              '{16'h1111, 16'h0042, 1'b1, 1'b0, 1'b0},
              '{16'h1112, 16'h0044, 1'b1, 1'b0, 1'b0},
              '{16'h1113, 16'h0046, 1'b1, 1'b0, 1'b0},
              '{16'h1114, 16'h0048, 1'b1, 1'b0, 1'b0},
              '{16'h2222, 16'h0050, 1'b1, 1'b1, 1'b1},
              '{16'hF000, 16'h0052, 1'b1, 1'b0, 1'b0}};
        e = '{'{16'hF000, 16'h0040, 1'b1, 1'b1, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1}};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(e[i]);
            cyc(s[i]);
            x = sb.pop_front();
            checks++;
            if (bus.id_instr_o !== x.instr || bus.id_valid_o !== x.valid || (x.chk_pc && bus.id_pc_plus2_o !== x.pc) ||
                bus.fetch_halt_o !== x.fh || bus.halted_o !== x.hd) begin
                errors++;
                $display("FAIL halt[%0d]: got instr=%h pc=%h v=%b fh=%b hd=%b want instr=%h pc=%h v=%b fh=%b hd=%b", i,
                         bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o, bus.halted_o,
                         x.instr, x.pc, x.valid, x.fh, x.hd);
            end
        end
    endtask

    task automatic test_flush_drain();
        stim_t s[6];
        exp_t  e[6];
        exp_t  x;
        do_reset();
        s = '{'{16'hF000, 16'h0060, 1'b1, 1'b0, 1'b0},
              '{16'h4444, 16'h0062, 1'b1, 1'b0, 1'b0},
              '{16'h4445, 16'h0064, 1'b1, 1'b0, 1'b1},
              '{16'h5555, 16'h0066, 1'b1, 1'b0, 1'b0},
              '{16'h5556, 16'h0068, 1'b1, 1'b0, 1'b0},
              '{16'h5557, 16'h006A, 1'b1, 1'b0, 1'b0}};
        e = '{'{16'hF000, 16'h0060, 1'b1, 1'b1, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0},
              '{16'h5555, 16'h0066, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'h5556, 16'h0068, 1'b1, 1'b1, 1'b0, 1'b0},
              '{16'h5557, 16'h006A, 1'b1, 1'b1, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(e[i]);
            cyc(s[i]);
            x = sb.pop_front();
            checks++;
            if (bus.id_instr_o !== x.instr || bus.id_valid_o !== x.valid || (x.chk_pc && bus.id_pc_plus2_o !== x.pc) ||
                bus.fetch_halt_o !== x.fh || bus.halted_o !== x.hd) begin
                errors++;
                $display("FAIL flush_drain[%0d]: got instr=%h pc=%h v=%b fh=%b hd=%b want instr=%h pc=%h v=%b fh=%b hd=%b", i,
                         bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o, bus.halted_o,
                         x.instr, x.pc, x.valid, x.fh, x.hd);
            end
        end
    endtask

    // Two stalled cycles during DRAIN push halted_o from row 4 to row 6.
    task automatic test_drain_stall();
        stim_t s[7];
        exp_t  e[7];
        exp_t  x;
        do_reset();
        s = '{'{16'hF000, 16'h0070, 1'b1, 1'b0, 1'b0},
              '{16'h6661, 16'h0072, 1'b1, 1'b0, 1'b0},
              '{16'h6662, 16'h0074, 1'b1, 1'b1, 1'b0},
              '{16'h6663, 16'h0076, 1'b1, 1'b1, 1'b0},
              '{16'h6664, 16'h0078, 1'b1, 1'b0, 1'b0},
              '{16'h6665, 16'h007A, 1'b1, 1'b0, 1'b0},
              '{16'h6666, 16'h007C, 1'b1, 1'b0, 1'b0}};
        e = '{'{16'hF000, 16'h0070, 1'b1, 1'b1, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
              '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1}};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(e[i]);
            cyc(s[i]);
            x = sb.pop_front();
            checks++;
            if (bus.id_instr_o !== x.instr || bus.id_valid_o !== x.valid || (x.chk_pc && bus.id_pc_plus2_o !== x.pc) ||
                bus.fetch_halt_o !== x.fh || bus.halted_o !== x.hd) begin
                errors++;
                $display("FAIL drain_stall[%0d]: got instr=%h pc=%h v=%b fh=%b hd=%b want instr=%h pc=%h v=%b fh=%b hd=%b", i,
                         bus.id_instr_o, bus.id_pc_plus2_o, bus.id_valid_o, bus.fetch_halt_o, bus.halted_o,
                         x.instr, x.pc, x.valid, x.fh, x.hd);
            end
        end
        // Asynchronous reset while HALTED, well away from any clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.halted_o !== 1'b0 || bus.fetch_halt_o !== 1'b0 || bus.id_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_halted: got hd=%b fh=%b v=%b want hd=0 fh=0 v=0",
                     bus.halted_o, bus.fetch_halt_o, bus.id_valid_o);
        end
        do_reset();
    endtask

`ifdef IFID_IMM_FIELDS_EN
    task automatic test_imm_fields();
        stim_t s;
        s = '{16'h1FF8, 16'h0080, 1'b1, 1'b0, 1'b0};
        cyc(s);
        checks++;
        if (bus.id_imm4_o !== 4'h8 || bus.id_imm9_o !== 9'h1F8 || bus.id_imm12_o !== 12'hFF8) begin
            errors++;
            $display("FAIL imm_fields: got imm4=%h imm9=%h imm12=%h want imm4=8 imm9=1f8 imm12=ff8",
                     bus.id_imm4_o, bus.id_imm9_o, bus.id_imm12_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_fake_hlt();
        test_halt();
        test_flush_drain();
        test_drain_stall();
`ifdef IFID_IMM_FIELDS_EN
        test_imm_fields();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
